// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush.
// Define IF_ID_MISALIGN_EN to tag fetches whose pc is not word aligned (inst forced to 0, id_except=1).
module if_id_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_except
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
`ifdef IF_ID_MISALIGN_EN
    logic              except;
`endif
  } entry_t;

  state_t state;
  entry_t main_e;
  entry_t skid_e;
  entry_t in_e;

  logic accept;
  logic drain;

  // if_ready depends only on held state and rst, never on id_ready.
  assign if_ready = ~skid_e.valid & ~rst;
  assign id_valid = main_e.valid;
  assign accept   = if_valid & if_ready;
  assign drain    = id_valid & id_ready;

  // NOTE: every field gets a default before any conditional override, so no latch is inferred.
  always_comb begin
    in_e       = '0;
    in_e.valid = 1'b1;
    in_e.pc    = if_pc;
    in_e.inst  = if_inst;
`ifdef IF_ID_MISALIGN_EN
    in_e.except = |if_pc[1:0];
    if (in_e.except) in_e.inst = '0;
`endif
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= EMPTY;
      main_e <= '0;
      skid_e <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_e <= in_e;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_e <= in_e;
          end else if (accept) begin
            skid_e <= in_e;
            state  <= FULL;
          end else if (drain) begin
            main_e <= '0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_e <= skid_e;
            skid_e <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_e <= '0;
          skid_e <= '0;
        end
      endcase
    end
  end

  // Invalid entries are stored zeroed, so the outputs show bubbles without extra gating.
  assign id_pc   = main_e.pc;
  assign id_inst = main_e.inst;
`ifdef IF_ID_MISALIGN_EN
  assign id_except = main_e.except;
`else
  assign id_except = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; outputs are sampled 1 time unit after each rising edge.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_except;

  int passed = 0;
  int total  = 0;

  if_id_skid_reg #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_except(id_except)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy);
    check({tag, ".id_valid"}, 64'(id_valid), 64'(v));
    check({tag, ".id_pc"},    64'(id_pc),    64'(pc));
    check({tag, ".id_inst"},  64'(id_inst),  64'(inst));
    check({tag, ".if_ready"}, 64'(if_ready), 64'(rdy));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // reset held two cycles
    tick();
    chk_out("reset1", 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk_out("reset2", 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset2.id_except", 64'(id_except), 64'h0);
    rst = 1'b0;
    #1;
    check("post_reset.if_ready", 64'(if_ready), 64'h1);

    // pass-through stream
    drive(1'b1, 32'h0, 32'h11, 1'b1);
    tick();
    chk_out("pass0", 1'b1, 32'h0, 32'h11, 1'b1);
    drive(1'b1, 32'h4, 32'h22, 1'b1);
    tick();
    chk_out("pass4", 1'b1, 32'h4, 32'h22, 1'b1);
    drive(1'b1, 32'h8, 32'h33, 1'b1);
    tick();
    chk_out("pass8", 1'b1, 32'h8, 32'h33, 1'b1);
    drive(1'b0, 32'hC, 32'h44, 1'b1);
    tick();
    chk_out("bubble", 1'b0, 32'h0, 32'h0, 1'b1);

    // skid absorb
    drive(1'b1, 32'h100, 32'hA1, 1'b1);
    tick();
    chk_out("skid_a", 1'b1, 32'h100, 32'hA1, 1'b1);
    drive(1'b1, 32'h104, 32'hA2, 1'b0);
    tick();
    chk_out("skid_full", 1'b1, 32'h100, 32'hA1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("skid_b", 1'b1, 32'h104, 32'hA2, 1'b1);
    tick();
    chk_out("skid_empty", 1'b0, 32'h0, 32'h0, 1'b1);

    // long stall: only two entries held, 0x308 never accepted
    drive(1'b1, 32'h300, 32'h31, 1'b0);
    tick();
    chk_out("stall_one", 1'b1, 32'h300, 32'h31, 1'b1);
    drive(1'b1, 32'h304, 32'h32, 1'b0);
    tick();
    chk_out("stall_full", 1'b1, 32'h300, 32'h31, 1'b0);
    drive(1'b1, 32'h308, 32'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall_hold", 1'b1, 32'h300, 32'h31, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("stall_drain1", 1'b1, 32'h304, 32'h32, 1'b1);
    tick();
    chk_out("stall_drain2", 1'b0, 32'h0, 32'h0, 1'b1);

    // flush while FULL with if_valid high
    drive(1'b1, 32'h400, 32'h41, 1'b0);
    tick();
    drive(1'b1, 32'h404, 32'h42, 1'b0);
    tick();
    chk_out("pre_flush", 1'b1, 32'h400, 32'h41, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h408, 32'h43, 1'b0);
    tick();
    chk_out("flush_full", 1'b0, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    drive(1'b1, 32'h200, 32'h55, 1'b1);
    tick();
    chk_out("after_flush", 1'b1, 32'h200, 32'h55, 1'b1);

    // flush in ONE with simultaneous accept and drain: both discarded
    flush = 1'b1;
    drive(1'b1, 32'h204, 32'h56, 1'b1);
    tick();
    chk_out("flush_one", 1'b0, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("flush_idle", 1'b0, 32'h0, 32'h0, 1'b1);

    // misaligned fetch
    drive(1'b1, 32'h102, 32'hDEADBEEF, 1'b1);
    tick();
`ifdef IF_ID_MISALIGN_EN
    chk_out("misalign", 1'b1, 32'h102, 32'h0, 1'b1);
    check("misalign.id_except", 64'(id_except), 64'h1);
`else
    chk_out("misalign", 1'b1, 32'h102, 32'hDEADBEEF, 1'b1);
    check("misalign.id_except", 64'(id_except), 64'h0);
`endif
    drive(1'b1, 32'h108, 32'h77, 1'b1);
    tick();
    chk_out("aligned", 1'b1, 32'h108, 32'h77, 1'b1);
    check("aligned.id_except", 64'(id_except), 64'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("bubble.id_except", 64'(id_except), 64'h0);

    // reset mid-operation while FULL
    drive(1'b1, 32'h500, 32'h61, 1'b0);
    tick();
    drive(1'b1, 32'h504, 32'h62, 1'b0);
    tick();
    chk_out("pre_reset", 1'b1, 32'h500, 32'h61, 1'b0);
    drive(1'b1, 32'h508, 32'h63, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_comb.if_ready", 64'(if_ready), 64'h0);
    tick();
    chk_out("mid_reset", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("after_reset", 1'b0, 32'h0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
